// File: rtl/calc_pkg.sv
// calc_core shared types: FSM states, operator/dtype codes, BCD helpers.
// Optional MOD support is controlled by CALC_MOD_EN (see calc_core).
package calc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_DONE
  } state_t;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;
  localparam int OP_MOD = 4;

  localparam logic [3:0] DT_UNSIGNED = 4'h0;
  localparam logic [3:0] DT_SIGNED   = 4'h1;

  localparam logic [13:0] W_D3 = 14'd1000;
  localparam logic [13:0] W_D2 = 14'd100;
  localparam logic [13:0] W_D1 = 14'd10;

  typedef struct packed {
    logic [3:0]  dtype;
    logic [4:0]  op;
    logic [15:0] src1;
    logic [15:0] src2;
  } cmd_t;

  function automatic logic bcd_ok(logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9)
        && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [13:0] bcd_to_bin(logic [15:0] v);
    return 14'(v[15:12]) * W_D3
         + 14'(v[11:8]) * W_D2
         + 14'(v[7:4]) * W_D1
         + 14'(v[3:0]);
  endfunction

endpackage

// File: rtl/calc_if.sv
// Command/result bundle between decoder, calc_core and response encoder.
// master drives commands; slave is the execution core.
interface calc_if;
  logic [3:0]  dtype;
  logic [4:0]  operator;
  logic [15:0] src1;
  logic [15:0] src2;
  logic        parser_done;
  logic [31:0] result;
  logic        result_valid;
  logic        err;
  logic        busy;

  modport master (
    output dtype, operator, src1, src2, parser_done,
    input  result, result_valid, err, busy
  );

  modport slave (
    input  dtype, operator, src1, src2, parser_done,
    output result, result_valid, err, busy
  );
endinterface

// File: rtl/calc_div16.sv
// Iterative restoring divider, one quotient bit per cycle.
// Remainder port exists only when CALC_MOD_EN is defined.
module calc_div16 #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        done,
  output logic [15:0] quotient
`ifdef CALC_MOD_EN
  ,
  output logic [15:0] remainder
`endif
);

  localparam int CW = $clog2(ITER + 1);

  logic [CW-1:0] cnt;
  logic          run;
  logic [15:0]   quo;
  logic [15:0]   rem;
  logic [15:0]   dvs;
  logic [16:0]   shl;
  logic [16:0]   diff;

  // rem < dvs always, so diff[16] is a clean borrow flag
  always_comb begin
    shl  = {rem, quo[15]};
    diff = shl - {1'b0, dvs};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
    end else if (start) begin
      cnt  <= '0;
      run  <= 1'b1;
      done <= 1'b0;
      quo  <= dividend;
      rem  <= '0;
      dvs  <= divisor;
    end else if (run) begin
      if (diff[16]) begin
        rem <= shl[15:0];
        quo <= {quo[14:0], 1'b0};
      end else begin
        rem <= diff[15:0];
        quo <= {quo[14:0], 1'b1};
      end
      cnt <= cnt + CW'(1);
      if (cnt == CW'(ITER - 1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign quotient = quo;
`ifdef CALC_MOD_EN
  assign remainder = rem;
`endif

endmodule

// File: rtl/calc_core.sv
// Calculator execution stage: BCD operands, add/sub, shift-add mul, div/mod.
// Define CALC_MOD_EN to support MOD; otherwise operator 5'b10000 is illegal.
module calc_core
  import calc_pkg::*;
#(
  parameter int ITER = 16
) (
  input logic   clk,
  input logic   n_rst,
  calc_if.slave bus
);

  localparam int CW = $clog2(ITER + 1);

  state_t        state;
  cmd_t          cmd;
  logic [13:0]   a_q;
  logic [13:0]   b_q;
  logic [31:0]   mcand;
  logic [31:0]   acc;
  logic [15:0]   mplier;
  logic [CW-1:0] cnt;
  logic [31:0]   result_q;
  logic          valid_q;
  logic          err_q;
  logic          busy_q;

  logic [13:0] a_bin;
  logic [13:0] b_bin;
  logic        op_legal;
  logic        dt_legal;
  logic        is_div;
  logic        ld_err;
  logic        dv_start;
  logic        dv_done;
  logic [15:0] dv_quo;
`ifdef CALC_MOD_EN
  logic [15:0] dv_rem;
`endif

  always_comb begin
    a_bin    = bcd_to_bin(cmd.src1);
    b_bin    = bcd_to_bin(cmd.src2);
    dt_legal = (cmd.dtype == DT_UNSIGNED) || (cmd.dtype == DT_SIGNED);
`ifdef CALC_MOD_EN
    op_legal = $onehot(cmd.op);
    is_div   = cmd.op[OP_DIV] | cmd.op[OP_MOD];
`else
    op_legal = $onehot(cmd.op) && !cmd.op[OP_MOD];
    is_div   = cmd.op[OP_DIV];
`endif
    ld_err   = !bcd_ok(cmd.src1) || !bcd_ok(cmd.src2)
            || !op_legal || !dt_legal
            || (is_div && b_bin == '0);
    dv_start = (state == S_LOAD) && !ld_err && is_div;
  end

  calc_div16 #(.ITER(ITER)) u_div (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (dv_start),
    .dividend ({2'b00, a_bin}),
    .divisor  ({2'b00, b_bin}),
    .done     (dv_done),
    .quotient (dv_quo)
`ifdef CALC_MOD_EN
    ,
    .remainder(dv_rem)
`endif
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      cmd      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      cnt      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.parser_done) begin
            cmd <= '{dtype: bus.dtype, op: bus.operator,
                     src1: bus.src1, src2: bus.src2};
            busy_q <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          a_q    <= a_bin;
          b_q    <= b_bin;
          mcand  <= 32'(a_bin);
          mplier <= 16'(b_bin);
          acc    <= '0;
          cnt    <= '0;
          if (ld_err) begin
            result_q <= '0;
            err_q    <= 1'b1;
            valid_q  <= 1'b1;
            state    <= S_DONE;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (1'b1)
            cmd.op[OP_ADD]: begin
              result_q <= 32'(a_q) + 32'(b_q);
              err_q    <= 1'b0;
              valid_q  <= 1'b1;
              state    <= S_DONE;
            end
            cmd.op[OP_SUB]: begin
              // unsigned results cannot go negative
              if (cmd.dtype == DT_UNSIGNED && a_q < b_q) begin
                result_q <= '0;
                err_q    <= 1'b1;
              end else begin
                result_q <= 32'(a_q) - 32'(b_q);
                err_q    <= 1'b0;
              end
              valid_q <= 1'b1;
              state   <= S_DONE;
            end
            cmd.op[OP_MUL]: begin
              if (cnt == CW'(ITER)) begin
                result_q <= acc;
                err_q    <= 1'b0;
                valid_q  <= 1'b1;
                state    <= S_DONE;
              end else begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
              end
            end
            cmd.op[OP_DIV]: begin
              if (dv_done) begin
                result_q <= 32'(dv_quo);
                err_q    <= 1'b0;
                valid_q  <= 1'b1;
                state    <= S_DONE;
              end
            end
`ifdef CALC_MOD_EN
            cmd.op[OP_MOD]: begin
              if (dv_done) begin
                result_q <= 32'(dv_rem);
                err_q    <= 1'b0;
                valid_q  <= 1'b1;
                state    <= S_DONE;
              end
            end
`endif
            default: begin
              result_q <= '0;
              err_q    <= 1'b1;
              valid_q  <= 1'b1;
              state    <= S_DONE;
            end
          endcase
        end
        S_DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.err          = err_q;
  assign bus.busy         = busy_q;

endmodule
